// File: rtl/timer_unit_pkg.sv
// Shared constants, register enum and CTRL layout for the four-channel timer block.
// Optional feature macro: TIMER_IRQ_EN (combined interrupt output and CTRL.irq_en).
package timer_unit_pkg;

  localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_4000;
  localparam int          TIMER_NUM       = 4;
  localparam int          CH_W            = 2;
  localparam int          PRE_W           = 16;

  typedef enum logic [1:0] {
    TMR_CTRL   = 2'd0,
    TMR_COUNT  = 2'd1,
    TMR_CMP    = 2'd2,
    TMR_STATUS = 2'd3
  } TimerReg_e;

  typedef struct packed {
    logic [PRE_W-1:0] pre;
    logic [12:0]      reserved;
    logic             irq_en;
    logic             auto_reload;
    logic             en;
  } TimerCtrl_s;

  // Byte address of one channel register inside the window.
  function automatic logic [31:0] timer_addr(input logic [CH_W-1:0] ch, input TimerReg_e r);
    return TIMER_BASE_ADDR | {26'b0, ch, r, 2'b00};
  endfunction

endpackage

// File: rtl/timer_unit_if.sv
// LSU-side bus between the MEM-stage load/store unit and the timer block.
// Optional feature macro: TIMER_IRQ_EN adds the o_irq line.
interface timer_unit_if;
  // No back-pressure: every access with i_lsu_valid high is accepted in that cycle;
  // a load that hits the window answers with a one-cycle o_lsu_rvalid pulse next cycle.
  logic        i_lsu_valid;
  logic        i_lsu_wen;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_rvalid;
`ifdef TIMER_IRQ_EN
  logic        o_irq;

  modport master (
    output i_lsu_valid, i_lsu_wen, i_lsu_addr, i_lsu_wdata,
    input  o_lsu_rdata, o_lsu_rvalid, o_irq
  );
  modport slave (
    input  i_lsu_valid, i_lsu_wen, i_lsu_addr, i_lsu_wdata,
    output o_lsu_rdata, o_lsu_rvalid, o_irq
  );
`else
  modport master (
    output i_lsu_valid, i_lsu_wen, i_lsu_addr, i_lsu_wdata,
    input  o_lsu_rdata, o_lsu_rvalid
  );
  modport slave (
    input  i_lsu_valid, i_lsu_wen, i_lsu_addr, i_lsu_wdata,
    output o_lsu_rdata, o_lsu_rvalid
  );
`endif
endinterface

// File: rtl/timer_unit_channel.sv
// One timer channel: CTRL/COUNT/CMP/STATUS registers, prescaler and match logic.
// Optional feature macro: TIMER_IRQ_EN makes CTRL.irq_en writable.
module timer_channel
  import timer_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  TimerReg_e   reg_sel,
  input  logic [31:0] wdata,
  output TimerCtrl_s  ctrl,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        match
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             hit_cmp;
  logic             clr_match;

  assign tick      = ctrl.en && (pre_cnt == ctrl.pre);
  assign hit_cmp   = tick && (count == cmp);
  assign clr_match = we && (reg_sel == TMR_STATUS) && wdata[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= '0;
      count   <= '0;
      cmp     <= '0;
      match   <= 1'b0;
      pre_cnt <= '0;
    end else begin
      // A disabled channel parks its prescaler at 0 so re-enable starts a fresh period.
      pre_cnt <= (!ctrl.en || tick) ? '0 : pre_cnt + 1'b1;

      if (hit_cmp) begin
        if (ctrl.auto_reload) count   <= '0;
        else                  ctrl.en <= 1'b0;
      end else if (tick) begin
        count <= count + 32'd1;
      end

      // Hardware set beats a same-cycle W1C.
      match <= hit_cmp | (match & ~clr_match);

      // Software stores land last so they override the tick update.
      if (we) begin
        case (reg_sel)
          TMR_CTRL: begin
            ctrl.pre         <= wdata[31:16];
`ifdef TIMER_IRQ_EN
            ctrl.irq_en      <= wdata[2];
`endif
            ctrl.auto_reload <= wdata[1];
            ctrl.en          <= wdata[0];
          end
          TMR_COUNT: count <= wdata;
          TMR_CMP:   cmp   <= wdata;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/timer_unit.sv
// Four-channel memory-mapped timer: address decode, read mux and registered load response.
// Optional feature macro: TIMER_IRQ_EN adds the registered combined interrupt o_irq.
module timer_unit
  import timer_unit_pkg::*;
(
  input logic          i_clk,
  input logic          i_rst_n,
  timer_unit_if.slave  lsu
);

  localparam logic [31:0] BASE = TIMER_BASE_ADDR;

  logic                 hit;
  logic                 hit_load;
  logic                 hit_store;
  logic [CH_W-1:0]      ch;
  TimerReg_e            reg_sel;
  TimerCtrl_s           ctrl  [TIMER_NUM];
  logic [31:0]          count [TIMER_NUM];
  logic [31:0]          cmp   [TIMER_NUM];
  logic [TIMER_NUM-1:0] match;
  logic [31:0]          rd_word;
  logic                 unused_addr_bits;

  assign hit       = lsu.i_lsu_valid && (lsu.i_lsu_addr[31:6] == BASE[31:6]);
  assign hit_load  = hit && !lsu.i_lsu_wen;
  assign hit_store = hit && lsu.i_lsu_wen;
  assign ch        = lsu.i_lsu_addr[5:4];
  assign reg_sel   = TimerReg_e'(lsu.i_lsu_addr[3:2]);
  assign unused_addr_bits = ^lsu.i_lsu_addr[1:0];

  for (genvar i = 0; i < TIMER_NUM; i++) begin : g_ch
    timer_channel u_ch (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .we      (hit_store && (ch == CH_W'(i))),
      .reg_sel (reg_sel),
      .wdata   (lsu.i_lsu_wdata),
      .ctrl    (ctrl[i]),
      .count   (count[i]),
      .cmp     (cmp[i]),
      .match   (match[i])
    );
  end

  // Loads see the register values of the access cycle, before that cycle's update.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      TMR_CTRL:   rd_word = ctrl[ch];
      TMR_COUNT:  rd_word = count[ch];
      TMR_CMP:    rd_word = cmp[ch];
      TMR_STATUS: rd_word = {31'b0, match[ch]};
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lsu.o_lsu_rdata  <= '0;
      lsu.o_lsu_rvalid <= 1'b0;
    end else begin
      lsu.o_lsu_rvalid <= hit_load;
      lsu.o_lsu_rdata  <= hit_load ? rd_word : '0;
    end
  end

`ifdef TIMER_IRQ_EN
  logic [TIMER_NUM-1:0] irq_src;

  for (genvar i = 0; i < TIMER_NUM; i++) begin : g_irq
    assign irq_src[i] = match[i] & ctrl[i].irq_en;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lsu.o_irq <= 1'b0;
    else          lsu.o_irq <= |irq_src;
  end
`endif

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit: directed tables and sequences plus random traffic against a behavioural model.
module tb_timer_unit;
  import timer_unit_pkg::*;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_unit_if lsu ();

  timer_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .lsu     (lsu)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_count [TIMER_NUM];
  logic [31:0] m_cmp   [TIMER_NUM];
  logic [15:0] m_pre   [TIMER_NUM];
  logic        m_en    [TIMER_NUM];
  logic        m_ar    [TIMER_NUM];
  logic        m_ie    [TIMER_NUM];
  logic        m_match [TIMER_NUM];
  int          m_age   [TIMER_NUM];  // cycles spent enabled since the enabling edge

  logic [31:0] exp_q[$];
  logic        exp_v_q[$];
  logic        exp_irq_q[$];

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rdata;
  logic        last_rvalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TIMER_NUM; i++) begin
      m_count[i] = '0; m_cmp[i] = '0; m_pre[i] = '0;
      m_en[i] = 1'b0; m_ar[i] = 1'b0; m_ie[i] = 1'b0; m_match[i] = 1'b0; m_age[i] = 0;
    end
    exp_q.delete(); exp_v_q.delete(); exp_irq_q.delete();
  endtask

  function automatic logic [31:0] m_read(input int ch, input int r);
    case (r)
      0:       return {m_pre[ch], 13'b0, m_ie[ch], m_ar[ch], m_en[ch]};
      1:       return m_count[ch];
      2:       return m_cmp[ch];
      default: return {31'b0, m_match[ch]};
    endcase
  endfunction

  // Advance the model by one clock edge with the given bus request.
  task automatic model_step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] base;
    logic        hit, irq, tick, set, en_was;
    int          ch, r;
    base = TIMER_BASE_ADDR;
    hit  = v && (a[31:6] == base[31:6]);
    ch   = int'(a[5:4]);
    r    = int'(a[3:2]);
    irq  = 1'b0;
    for (int i = 0; i < TIMER_NUM; i++) irq = irq | (m_match[i] & m_ie[i]);
    exp_irq_q.push_back(irq);
    exp_v_q.push_back(hit && !w);
    exp_q.push_back((hit && !w) ? m_read(ch, r) : 32'h0);
    for (int i = 0; i < TIMER_NUM; i++) begin
      en_was = m_en[i];
      tick   = m_en[i] && ((m_age[i] % (int'(m_pre[i]) + 1)) == int'(m_pre[i]));
      set    = 1'b0;
      if (tick) begin
        if (m_count[i] == m_cmp[i]) begin
          set = 1'b1;
          if (m_ar[i]) m_count[i] = 32'h0;
          else         m_en[i] = 1'b0;
        end else begin
          m_count[i] = m_count[i] + 32'd1;
        end
      end
      if (hit && w && ch == i) begin
        case (r)
          0: begin
            m_pre[i] = d[31:16];
`ifdef TIMER_IRQ_EN
            m_ie[i] = d[2];
`else
            m_ie[i] = 1'b0;
`endif
            m_ar[i] = d[1];
            m_en[i] = d[0];
          end
          1: m_count[i] = d;
          2: m_cmp[i] = d;
          default: if (d[0]) m_match[i] = 1'b0;
        endcase
      end
      if (set) m_match[i] = 1'b1;
      m_age[i] = (m_en[i] && en_was) ? m_age[i] + 1 : 0;
    end
  endtask

  task automatic check_step();
    logic [31:0] ed;
    logic        ev, ei;
    ed = exp_q.pop_front();
    ev = exp_v_q.pop_front();
    ei = exp_irq_q.pop_front();
    last_rdata  = lsu.o_lsu_rdata;
    last_rvalid = lsu.o_lsu_rvalid;
    chk("model_rvalid", {31'b0, last_rvalid}, {31'b0, ev});
    chk("model_rdata", last_rdata, ed);
`ifdef TIMER_IRQ_EN
    chk("model_irq", {31'b0, lsu.o_irq}, {31'b0, ei});
`else
    if (ei !== 1'b0) chk("model_irq_off", {31'b0, ei}, 32'h0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    lsu.i_lsu_valid = v;
    lsu.i_lsu_wen   = w;
    lsu.i_lsu_addr  = a;
    lsu.i_lsu_wdata = d;
    model_step(v, w, a, d);
    @(posedge clk);
    #1;
    check_step();
  endtask

  task automatic ld(input logic [31:0] a);
    drive(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rvalid"}, {31'b0, lsu.o_lsu_rvalid}, 32'h0);
    chk({tag, "_rdata"}, lsu.o_lsu_rdata, 32'h0);
`ifdef TIMER_IRQ_EN
    chk({tag, "_irq"}, {31'b0, lsu.o_irq}, 32'h0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    vec_t        vecs[11];
    logic [31:0] exp_os[8];
    logic [15:0] chan_pre[TIMER_NUM];
    logic [31:0] a, d;
    logic [1:0]  ch, r;
    int          kind;

    // Auto-reload on channel 0: CMP=3, CTRL=en|auto_reload, pre=0.
    vecs[0]  = '{1'b1, 32'h4008, 32'd3, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 32'h4000, 32'd3, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 32'h4004, 32'd0, 1'b1, 32'd0};
    vecs[3]  = '{1'b0, 32'h4004, 32'd0, 1'b1, 32'd1};
    vecs[4]  = '{1'b0, 32'h4004, 32'd0, 1'b1, 32'd2};
    vecs[5]  = '{1'b0, 32'h4004, 32'd0, 1'b1, 32'd3};
    vecs[6]  = '{1'b0, 32'h4004, 32'd0, 1'b1, 32'd0};
    vecs[7]  = '{1'b0, 32'h400C, 32'd0, 1'b1, 32'd1};
    vecs[8]  = '{1'b1, 32'h400C, 32'd1, 1'b0, 32'd0};
    vecs[9]  = '{1'b0, 32'h400C, 32'd0, 1'b1, 32'd0};
    vecs[10] = '{1'b0, 32'h400C, 32'd0, 1'b1, 32'd1};
    exp_os = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};

    // Reset, with a load presented while reset is held.
    lsu.i_lsu_valid = 1'b1;
    lsu.i_lsu_wen   = 1'b0;
    lsu.i_lsu_addr  = 32'h4000;
    lsu.i_lsu_wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      ld(32'h4000 + 32'(i * 4));
      chk("reset_val_rdata", last_rdata, 32'h0);
      chk("reset_val_rvalid", {31'b0, last_rvalid}, 32'h1);
      idle();
      chk("reset_gap_rvalid", {31'b0, last_rvalid}, 32'h0);
    end

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].w, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("autoreload_rvalid_%0d", i), {31'b0, last_rvalid}, {31'b0, vecs[i].exp_v});
      chk($sformatf("autoreload_rdata_%0d", i), last_rdata, vecs[i].exp_d);
    end
    st(32'h4000, 32'h0);

    // One-shot with pre=2 on channel 1.
    st(32'h4018, 32'd1);
    st(32'h4010, 32'h0002_0001);
    for (int k = 0; k < 8; k++) begin
      ld(32'h4014);
      chk($sformatf("oneshot_count_%0d", k), last_rdata, exp_os[k]);
    end
    ld(32'h4010);
    chk("oneshot_ctrl", last_rdata, 32'h0002_0000);
    ld(32'h401C);
    chk("oneshot_status", last_rdata, 32'h1);

    // Wrap on channel 2.
    st(32'h4028, 32'd5);
    st(32'h4024, 32'hFFFF_FFFF);
    st(32'h4020, 32'h1);
    ld(32'h4024);
    chk("wrap_before", last_rdata, 32'hFFFF_FFFF);
    ld(32'h4024);
    chk("wrap_after", last_rdata, 32'h0);
    st(32'h4020, 32'h0);

    // Collisions on channel 3.
    st(32'h4038, 32'd100);
    st(32'h4030, 32'h1);
    idle();
    idle();
    st(32'h4034, 32'h50);
    ld(32'h4034);
    chk("count_store_wins", last_rdata, 32'h50);
    st(32'h4038, 32'h53);
    idle();
    st(32'h403C, 32'h1);
    ld(32'h403C);
    chk("set_beats_w1c", last_rdata, 32'h1);
    ld(32'h4034);
    chk("oneshot_hold", last_rdata, 32'h53);
    ld(32'h4030);
    chk("oneshot_en_clear", last_rdata, 32'h0);

`ifdef TIMER_IRQ_EN
    // Interrupt on channel 2.
    st(32'h4024, 32'h0);
    st(32'h4028, 32'h1);
    st(32'h4020, 32'h7);
    idle();
    idle();
    chk("irq_before", {31'b0, lsu.o_irq}, 32'h0);
    idle();
    chk("irq_rise", {31'b0, lsu.o_irq}, 32'h1);
    st(32'h4020, 32'h4);
    st(32'h402C, 32'h1);
    chk("irq_hold", {31'b0, lsu.o_irq}, 32'h1);
    idle();
    chk("irq_drop", {31'b0, lsu.o_irq}, 32'h0);
`endif
    ld(32'h4100);
    chk("outside_rvalid", {31'b0, last_rvalid}, 32'h0);
    chk("outside_rdata", last_rdata, 32'h0);

    // Random traffic; each channel keeps one prescaler value so it never changes while running.
    for (int i = 0; i < TIMER_NUM; i++) begin
      st(timer_addr(2'(i), TMR_CTRL), 32'h0);
      chan_pre[i] = 16'($urandom_range(0, 3));
    end
    for (int n = 0; n < 1500; n++) begin
      kind = $urandom_range(0, 9);
      ch   = 2'($urandom_range(0, 3));
      r    = 2'($urandom_range(0, 3));
      a    = timer_addr(ch, TimerReg_e'(r));
      if (kind == 0) begin
        idle();
      end else if (kind == 1) begin
        case ($urandom_range(0, 2))
          0:       ld(32'h4100);
          1:       ld(32'h3FFC);
          default: ld(32'h4040 | {28'b0, r, 2'b00});
        endcase
      end else if (kind == 2) begin
        st(32'h4040 | {28'b0, r, 2'b00}, $urandom);
      end else if (kind <= 6) begin
        ld(a);
      end else begin
        case (r)
          2'd0:    d = {chan_pre[ch], 13'($urandom), 3'($urandom)};
          2'd1:    d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 12));
          2'd2:    d = 32'($urandom_range(0, 12));
          default: d = $urandom;
        endcase
        st(a, d);
      end
      if (n == 700) begin
        ld(timer_addr(2'd0, TMR_COUNT));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
